// File: rtl/bf_sdf_i_if.sv
// Sample bus of one SDF butterfly stage: input sample side (iaddr/idata/ien)
// and registered output side (oaddr/odata/oen).
interface bf_sdf_i_if #(
  parameter int TOTAL_STAGE = 7,
  parameter int CPLX_WIDTH  = 32
);
  logic [TOTAL_STAGE-1:0] iaddr;
  logic [CPLX_WIDTH-1:0]  idata;
  logic                   ien;
  logic [TOTAL_STAGE-1:0] oaddr;
  logic [CPLX_WIDTH-1:0]  odata;
  logic                   oen;

  modport master (output iaddr, idata, ien, input oaddr, odata, oen);
  modport slave  (input iaddr, idata, ien, output oaddr, odata, oen);
endinterface

// File: rtl/bf_sdf_i.sv
// Radix-2 single-path delay-feedback butterfly for one FFT stage (delay D = 2^(FFT_STG-1)).
// Define BF_SCALE_EN for a floor halving of every sum/difference instead of wrap-around.
module bf_sdf_i #(
  parameter int FFT_STG     = 7,
  parameter int TOTAL_STAGE = 7,
  parameter int REAL_WIDTH  = 16,
  parameter int CPLX_WIDTH  = 2 * REAL_WIDTH
) (
  input  logic      iclk,
  input  logic      irst,
  bf_sdf_i_if.slave bus
);
  localparam int DEPTH = 1 << (FFT_STG - 1);
  localparam int PW    = (FFT_STG > 1) ? FFT_STG - 1 : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
`ifdef BF_SCALE_EN
  localparam int SHIFT = 1;
`else
  localparam int SHIFT = 0;
`endif

  logic [PW-1:0]          ptr;
  logic                   mem_valid [DEPTH];
  logic [TOTAL_STAGE-1:0] mem_addr  [DEPTH];
  logic [CPLX_WIDTH-1:0]  mem_data  [DEPTH];

  logic                    e_valid;
  logic [TOTAL_STAGE-1:0]  e_addr;
  logic [CPLX_WIDTH-1:0]   e_data;
  logic                    phase;
  logic signed [REAL_WIDTH:0] sum_re, sum_im, dif_re, dif_im;
  logic [CPLX_WIDTH-1:0]   out_data;
  logic [CPLX_WIDTH-1:0]   wr_data;
  logic                    wr_valid;

  // Extra-bit result brought back to REAL_WIDTH: floor halving or plain wrap.
  function automatic logic [REAL_WIDTH-1:0] reduce(input logic signed [REAL_WIDTH:0] v);
    return REAL_WIDTH'(v >>> SHIFT);
  endfunction

  always_comb begin
    e_valid  = mem_valid[ptr];
    e_addr   = mem_addr[ptr];
    e_data   = mem_data[ptr];
    phase    = bus.iaddr[FFT_STG-1];
    sum_re   = {e_data[CPLX_WIDTH-1], e_data[CPLX_WIDTH-1 -: REAL_WIDTH]}
             + {bus.idata[CPLX_WIDTH-1], bus.idata[CPLX_WIDTH-1 -: REAL_WIDTH]};
    sum_im   = {e_data[REAL_WIDTH-1], e_data[REAL_WIDTH-1:0]}
             + {bus.idata[REAL_WIDTH-1], bus.idata[REAL_WIDTH-1:0]};
    dif_re   = {e_data[CPLX_WIDTH-1], e_data[CPLX_WIDTH-1 -: REAL_WIDTH]}
             - {bus.idata[CPLX_WIDTH-1], bus.idata[CPLX_WIDTH-1 -: REAL_WIDTH]};
    dif_im   = {e_data[REAL_WIDTH-1], e_data[REAL_WIDTH-1:0]}
             - {bus.idata[REAL_WIDTH-1], bus.idata[REAL_WIDTH-1:0]};
    out_data = e_data;
    wr_data  = bus.idata;
    wr_valid = 1'b1;
    // Second half-block: emit the sum, park the difference for the next fill phase.
    if (phase) begin
      out_data = {reduce(sum_re), reduce(sum_im)};
      wr_data  = {reduce(dif_re), reduce(dif_im)};
      wr_valid = e_valid;
    end
  end

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      ptr       <= '0;
      bus.oen   <= 1'b0;
      bus.oaddr <= '0;
      bus.odata <= '0;
      for (int i = 0; i < DEPTH; i++) mem_valid[i] <= 1'b0;
    end else if (bus.ien) begin
      mem_valid[ptr] <= wr_valid;
      ptr            <= (ptr == PTR_LAST) ? '0 : ptr + PW'(1);
      bus.oen        <= e_valid;
      bus.oaddr      <= e_addr;
      bus.odata      <= out_data;
    end else begin
      bus.oen <= 1'b0;
    end
  end

  // Address/data payload needs no reset; the valid bits gate it.
  always_ff @(posedge iclk) begin
    if (bus.ien) begin
      mem_addr[ptr] <= bus.iaddr;
      mem_data[ptr] <= wr_data;
    end
  end
endmodule

// File: tb/tb_bf_sdf_i.sv
// Scoreboard bench for bf_sdf_i: a small D=2 instance for directed frames and
// overflow, and a default D=64 instance for random stalls, imag-only and mid-frame reset.
module tb_bf_sdf_i;
  localparam int RW    = 16;
  localparam int CW    = 32;
  localparam int STG_S = 2;
  localparam int STG_B = 7;

  typedef struct {
    logic [6:0]  addr;
    logic [31:0] data;
  } samp_t;

  typedef struct {
    logic        valid;
    logic [6:0]  addr;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  samp_t hist [2][$];
  exp_t  expq [2][$];

  bf_sdf_i_if #(.TOTAL_STAGE(STG_S), .CPLX_WIDTH(CW)) bus_s ();
  bf_sdf_i_if #(.TOTAL_STAGE(STG_B), .CPLX_WIDTH(CW)) bus_b ();

  bf_sdf_i #(.FFT_STG(STG_S), .TOTAL_STAGE(STG_S), .REAL_WIDTH(RW), .CPLX_WIDTH(CW)) dut_s (
    .iclk (clk),
    .irst (rst),
    .bus  (bus_s)
  );

  bf_sdf_i #(.FFT_STG(STG_B), .TOTAL_STAGE(STG_B), .REAL_WIDTH(RW), .CPLX_WIDTH(CW)) dut_b (
    .iclk (clk),
    .irst (rst),
    .bus  (bus_b)
  );

  always #5 clk = ~clk;

  function automatic int re(input logic [31:0] d);
    return int'($signed(d[31:16]));
  endfunction

  function automatic int im(input logic [31:0] d);
    return int'($signed(d[15:0]));
  endfunction

  function automatic logic [15:0] red(input int v);
    int r;
`ifdef BF_SCALE_EN
    r = v >>> 1;
`else
    r = v;
`endif
    return r[15:0];
  endfunction

  // Reference: the output triggered by accepted sample j belongs to sample j-D;
  // a first-half sample gets x[j-D]+x[j], a second-half one gets x[j-2D]-x[j-D].
  task automatic modelAccept(input int which, input logic [6:0] addr, input logic [31:0] data);
    samp_t s, p, q;
    exp_t  e;
    int    stg, d, j;
    stg = (which == 1) ? STG_B : STG_S;
    d   = 1 << (stg - 1);
    s.addr = addr;
    s.data = data;
    j = hist[which].size();
    hist[which].push_back(s);
    e.valid = 1'b0;
    e.addr  = '0;
    e.data  = '0;
    if (j >= d) begin
      p = hist[which][j-d];
      if (p.addr[stg-1] == 1'b0) begin
        e.valid = 1'b1;
        e.addr  = p.addr;
        e.data  = {red(re(p.data) + re(s.data)), red(im(p.data) + im(s.data))};
      end else if (j >= 2 * d) begin
        q = hist[which][j-2*d];
        e.valid = 1'b1;
        e.addr  = p.addr;
        e.data  = {red(re(q.data) - re(p.data)), red(im(q.data) - im(p.data))};
      end
    end
    expq[which].push_back(e);
  endtask

  task automatic applyStimulus(input int which, input logic [6:0] addr, input logic [31:0] data,
                               input logic en);
    if (which == 0) begin
      bus_s.iaddr = addr[1:0];
      bus_s.idata = data;
      bus_s.ien   = en;
      bus_b.ien   = 1'b0;
    end else begin
      bus_b.iaddr = addr;
      bus_b.idata = data;
      bus_b.ien   = en;
      bus_s.ien   = 1'b0;
    end
    if (en) modelAccept(which, addr, data);
    @(posedge clk);
    #1;
  endtask

  // kind: 0 random, 1 real ramp, 2 imag ramp, 3 real 0x7FFF, 4 zeros
  task automatic sendFrame(input int which, input int kind, input int gap_pct);
    int n;
    logic [31:0] d;
    n = (which == 1) ? (1 << STG_B) : (1 << STG_S);
    for (int a = 0; a < n; a++) begin
      while ($urandom_range(0, 99) < gap_pct) applyStimulus(which, 7'd0, 32'd0, 1'b0);
      case (kind)
        0:       d = $urandom();
        1:       d = {16'(a + 1), 16'h0000};
        2:       d = {16'h0000, 16'(a + 1)};
        3:       d = {16'h7FFF, 16'h0000};
        default: d = 32'd0;
      endcase
      applyStimulus(which, 7'(a), d, 1'b1);
    end
  endtask

  task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input int which, input logic was_acc, input logic oen,
                             input logic [6:0] oaddr, input logic [31:0] odata);
    exp_t e;
    checks++;
    if (rst) begin
      if (oen !== 1'b0) begin
        errors++;
        $display("[TB] FAIL rst_oen_%0d: oen=%b expected 0", which, oen);
      end
    end else if (!was_acc) begin
      if (oen !== 1'b0) begin
        errors++;
        $display("[TB] FAIL idle_oen_%0d: oen=%b expected 0", which, oen);
      end
    end else if (expq[which].size() == 0) begin
      errors++;
      $display("[TB] FAIL sb_underflow_%0d: oen=%b with no expectation queued", which, oen);
    end else begin
      e = expq[which].pop_front();
      if (oen !== e.valid || (e.valid && (oaddr !== e.addr || odata !== e.data))) begin
        errors++;
        $display("[TB] FAIL out_%0d: oen=%b addr=%h data=%h, expected oen=%b addr=%h data=%h",
                 which, oen, oaddr, odata, e.valid, e.addr, e.data);
      end
    end
  endtask

  // Monitor: note what was accepted at the edge, compare on the following falling edge.
  initial begin
    logic acc_s, acc_b;
    forever begin
      @(posedge clk);
      acc_s = bus_s.ien && !rst;
      acc_b = bus_b.ien && !rst;
      @(negedge clk);
      checkOutput(0, acc_s, bus_s.oen, {5'd0, bus_s.oaddr}, bus_s.odata);
      checkOutput(1, acc_b, bus_b.oen, bus_b.oaddr, bus_b.odata);
    end
  end

  initial begin
    bus_s.iaddr = '0; bus_s.idata = '0; bus_s.ien = 1'b0;
    bus_b.iaddr = '0; bus_b.idata = '0; bus_b.ien = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkEq("reset_oen_s",   32'(bus_s.oen),   32'd0);
    checkEq("reset_oaddr_s", 32'(bus_s.oaddr), 32'd0);
    checkEq("reset_odata_s", bus_s.odata,      32'd0);
    checkEq("reset_oen_b",   32'(bus_b.oen),   32'd0);
    checkEq("reset_oaddr_b", 32'(bus_b.oaddr), 32'd0);
    checkEq("reset_odata_b", bus_b.odata,      32'd0);
    rst = 1'b0;
    applyStimulus(0, 7'd0, 32'd0, 1'b0);

    $display("[TB] D=2 ramp frames and overflow");
    sendFrame(0, 1, 0);
    sendFrame(0, 1, 0);
    sendFrame(0, 3, 0);
    sendFrame(0, 4, 0);
    sendFrame(0, 1, 40);
    sendFrame(0, 4, 0);
    applyStimulus(0, 7'd0, 32'd0, 1'b0);

    $display("[TB] D=64 gap-free and stalled random frames");
    sendFrame(1, 0, 0);
    for (int f = 0; f < 3; f++) sendFrame(1, 0, 30);
    sendFrame(1, 2, 0);
    sendFrame(1, 2, 0);

    $display("[TB] D=64 reset at sample 40");
    sendFrame(1, 0, 0);
    for (int a = 0; a <= 40; a++) applyStimulus(1, 7'(a), $urandom(), 1'b1);
    #1;
    rst = 1'b1;
    bus_b.ien = 1'b0;
    #1;
    checkEq("oen_async_rst", 32'(bus_b.oen), 32'd0);
    hist[1].delete();
    expq[1].delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    sendFrame(1, 0, 0);
    sendFrame(1, 0, 0);
    for (int f = 0; f < 4; f++) sendFrame(1, 0, 10);
    sendFrame(1, 4, 0);
    repeat (3) applyStimulus(1, 7'd0, 32'd0, 1'b0);

    checkEq("sb_empty_s", 32'(expq[0].size()), 32'd0);
    checkEq("sb_empty_b", 32'(expq[1].size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
